hls_deadlock_report_arbiter: RTL and testbench

- Shares one deadlock-report channel among NUM_MON per-instance HLS deadlock monitors. Each monitor drives a registered block flag.
- Round-robin selects one asserted monitor. Confirms the block persists for THRESH consecutive cycles, then emits one timestamped report over a valid/ready handshake.
- Holds a sticky deadlock flag until software clears it.
- Sits at design-wrapper level between the monitor tree's block outputs and the debug/status AXI-lite bridge.

---
 rtl/hls_deadlock_report_arbiter.sv | 128 ++++++++++++
 tb/tb_hls_deadlock_report_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report_arbiter.sv
// Deadlock report arbiter: round-robin picks one blocked monitor, confirms the block
// persists for THRESH cycles, then raises one timestamped report and holds a sticky
// deadlock flag until software clears it.
module hls_deadlock_report_arbiter #(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_MON),
    parameter int unsigned THRESH  = 16,
    parameter int unsigned TS_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] block_sigs,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [IDX_W-1:0]   report_idx,
    output logic [TS_W-1:0]    report_ts,
    output logic               deadlock,
    output logic               confirming
);

    typedef enum logic [1:0] {StScan, StConfirm, StReport, StHold} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cand_q, cand_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [TS_W-1:0]    first_ts_q, first_ts_d;

    logic [IDX_W-1:0]   sel;
    logic               sel_found;
    logic [7:0]         cnt_inc;
    int unsigned        pos;

    // Advance an index by one, wrapping at NUM_MON (need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (32'(v) == NUM_MON - 1) ? '0 : v + 1'b1;
    endfunction

    // Rotating-priority search: first set flag starting at ptr.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        pos       = 0;
        for (int unsigned i = 0; i < NUM_MON; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= NUM_MON) pos = pos - NUM_MON;
            if (!sel_found && block_sigs[IDX_W'(pos)]) begin
                sel       = IDX_W'(pos);
                sel_found = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state logic for the scan/confirm/report/hold sequence and the timestamp.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        first_ts_d = first_ts_q;
        ts_d       = enable ? ts_q + 1'b1 : ts_q;

        unique case (state_q)
            StScan: begin
                if (enable && sel_found) begin
                    cand_d     = sel;
                    cnt_d      = 8'd1;
                    first_ts_d = ts_q;
                    state_d    = (THRESH == 1) ? StReport : StConfirm;
                end
            end
            StConfirm: begin
                if (!enable || !block_sigs[cand_q]) begin
                    // Rotate past a flapping monitor so it cannot starve the others.
                    state_d = StScan;
                    cnt_d   = 8'd0;
                    ptr_d   = wrap_inc(cand_q);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(THRESH)) state_d = StReport;
                end
            end
            StReport: begin
                // Once raised, a report always completes; enable/clear are ignored.
                if (report_ready) state_d = StHold;
            end
            StHold: begin
                if (clear) begin
                    state_d = StScan;
                    cnt_d   = 8'd0;
                    ptr_d   = wrap_inc(cand_q);
                end
            end
            default: state_d = StScan;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StScan;
            ptr_q      <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            ts_q       <= '0;
            first_ts_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            first_ts_q <= first_ts_d;
        end
    end

    assign report_valid = (state_q == StReport);
    assign deadlock     = (state_q == StReport) || (state_q == StHold);
    assign confirming   = (state_q == StConfirm);
    assign report_idx   = cand_q;
    assign report_ts    = first_ts_q;

endmodule

// File: tb/tb_hls_deadlock_report_arbiter.sv
// Bench for hls_deadlock_report_arbiter: two instances (THRESH=16 and THRESH=1) share
// stimulus; a behavioural model predicts reports into queues, a monitor pops and compares.
module tb_hls_deadlock_report_arbiter;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] ts;
    } rep_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       report_ready = 1'b0;
    logic [3:0] block_sigs = 4'b0;

    logic        rv0, rv1, dl0, dl1, cf0, cf1;
    logic [1:0]  ri0, ri1;
    logic [31:0] rt0, rt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    // Model state, one slot per instance.
    int          m_ptr[2];
    int          m_cand[2];
    int          m_run[2];
    bit          m_busy[2];
    bit          m_pend[2];
    bit          m_hold[2];
    logic [31:0] m_first[2];
    logic [31:0] m_ts;
    rep_t        q0[$];
    rep_t        q1[$];

    always #5 clock = ~clock;

    hls_deadlock_report_arbiter #(.NUM_MON(4), .THRESH(16), .TS_W(32)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .block_sigs(block_sigs),
        .clear(clear), .report_valid(rv0), .report_ready(report_ready),
        .report_idx(ri0), .report_ts(rt0), .deadlock(dl0), .confirming(cf0)
    );

    hls_deadlock_report_arbiter #(.NUM_MON(4), .THRESH(1), .TS_W(32)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .block_sigs(block_sigs),
        .clear(clear), .report_valid(rv1), .report_ready(report_ready),
        .report_idx(ri1), .report_ts(rt1), .deadlock(dl1), .confirming(cf1)
    );

    task automatic cmp(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic raise(input int d);
        rep_t r;
        r.idx     = 2'(m_cand[d]);
        r.ts      = m_first[d];
        m_pend[d] = 1'b1;
        if (d == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // Behavioural model: watch a candidate until it has been seen blocked THRESH
    // consecutive cycles, then one report; rotate past the candidate whenever it is dropped.
    task automatic model_step(input int d);
        int  thr;
        bit  found;
        thr = (d == 0) ? 16 : 1;
        if (!reset) begin
            m_ptr[d] = 0; m_cand[d] = 0; m_run[d] = 0; m_first[d] = '0;
            m_busy[d] = 0; m_pend[d] = 0; m_hold[d] = 0;
            if (d == 0) q0.delete();
            else q1.delete();
        end else if (m_pend[d]) begin
            if (report_ready) begin
                m_pend[d] = 0;
                m_hold[d] = 1;
            end
        end else if (m_hold[d]) begin
            if (clear) begin
                m_hold[d] = 0;
                m_ptr[d]  = (m_cand[d] + 1) % 4;
            end
        end else if (m_busy[d]) begin
            if (!enable || !block_sigs[2'(m_cand[d])]) begin
                m_busy[d] = 0;
                m_ptr[d]  = (m_cand[d] + 1) % 4;
            end else begin
                m_run[d]++;
                if (m_run[d] == thr) begin
                    m_busy[d] = 0;
                    raise(d);
                end
            end
        end else if (enable && block_sigs != 4'b0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && block_sigs[2'((m_ptr[d] + k) % 4)]) begin
                    found     = 1;
                    m_cand[d] = (m_ptr[d] + k) % 4;
                end
            end
            m_first[d] = m_ts;
            m_run[d]   = 1;
            if (m_run[d] == thr) raise(d);
            else m_busy[d] = 1;
        end
    endtask

    // Model advances on the same edge the DUTs sample.
    always @(posedge clock) begin
        model_step(0);
        model_step(1);
        if (!reset) begin
            m_ts     = '0;
            checking = 1'b1;
        end else if (enable) begin
            m_ts = m_ts + 32'd1;
        end
    end

    task automatic check_dut(input int d, input logic rv, input logic [1:0] ri,
                             input logic [31:0] rt, input logic dl, input logic cf);
        rep_t front;
        bit   have;
        cmp("report_valid", d, 64'(rv), 64'(m_pend[d]));
        cmp("deadlock", d, 64'(dl), 64'(m_pend[d] | m_hold[d]));
        cmp("confirming", d, 64'(cf), 64'(m_busy[d]));
        if (rv === 1'b1) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_report dut%0d t=%0t: got idx %0h ts %0h, none expected",
                         d, $time, ri, rt);
            end else begin
                front = (d == 0) ? q0[0] : q1[0];
                cmp("report_idx", d, 64'(ri), 64'(front.idx));
                cmp("report_ts", d, 64'(rt), 64'(front.ts));
                // Transfer happens at the coming edge unless reset intervenes.
                if (report_ready && reset) begin
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (checking) begin
            check_dut(0, rv0, ri0, rt0, dl0, cf0);
            check_dut(1, rv1, ri1, rt1, dl1, cf1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset, then idle with enable high so the timestamp reaches 100.
        reset = 1'b0;
        cyc(3);
        reset = 1'b1; enable = 1'b1; block_sigs = 4'b0;
        cyc(100);

        // Basic confirm on monitor 2 with ready high, then clear.
        report_ready = 1'b1;
        block_sigs = 4'b0100;
        cyc(25);
        block_sigs = 4'b0;
        pulse_clear();
        cyc(5);

        // Glitch: 15 cycles then low, no report from the THRESH=16 instance.
        block_sigs = 4'b0010;
        cyc(15);
        block_sigs = 4'b0;
        cyc(5);
        pulse_clear();

        // Round robin from ptr=0 with 1010 persistent.
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        block_sigs = 4'b1010;
        for (int r = 0; r < 3; r++) begin
            cyc(20);
            pulse_clear();
        end

        // Backpressure: ready low while inputs toggle and clear pulses.
        report_ready = 1'b0;
        cyc(17);
        for (int i = 0; i < 20; i++) begin
            block_sigs = 4'($urandom);
            clear      = (i % 5 == 2);
            enable     = (i % 7 != 3);
            cyc(1);
        end
        clear = 1'b0; enable = 1'b1;
        report_ready = 1'b1;
        cyc(3);
        pulse_clear();

        // Reset in the middle of a pending report.
        report_ready = 1'b0;
        block_sigs = 4'b0001;
        cyc(18);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(3);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) block_sigs = 4'($urandom);
            enable       = ($urandom_range(15) != 0);
            clear        = ($urandom_range(9) == 0);
            report_ready = ($urandom_range(1) == 0);
            reset        = ($urandom_range(499) != 0);
            cyc(1);
        end
        reset = 1'b1; clear = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
